// File: rtl/elevator_plant_model.sv
// Behavioural N-floor elevator car and door plant with travel delays and limit stops.
// Optional sticky illegal-command flag: define PLANT_FAULT_EN to add the fault port.
module elevator_plant_model #(
  parameter int FLOORS       = 8,
  parameter int FLOOR_WIDTH  = 3,
  parameter int DELAY_ENGINE = 10,
  parameter int DELAY_DOOR   = 10,
  parameter int START_FLOOR  = 0
) (
  input  logic                   clock,
  input  logic                   an_reset,
  input  logic [1:0]             engine,
  input  logic [1:0]             door,
  output logic [1:0]             sensor_door,
  output logic [FLOORS-1:0]      floor_sensor,
  output logic [FLOOR_WIDTH-1:0] floor_pos,
  output logic                   sensor_up,
  output logic                   sensor_down
`ifdef PLANT_FAULT_EN
  ,
  output logic                   fault
`endif
);

  localparam int TICK_W = $clog2(DELAY_ENGINE);
  localparam int DPOS_W = $clog2(DELAY_DOOR + 1);

  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(FLOORS - 1);
  localparam logic [FLOOR_WIDTH-1:0] RST_FLOOR   = FLOOR_WIDTH'(START_FLOOR);
  localparam logic [TICK_W-1:0]      TICK_LAST   = TICK_W'(DELAY_ENGINE - 1);
  localparam logic [DPOS_W-1:0]      DPOS_OPEN   = DPOS_W'(DELAY_DOOR);
  localparam logic [FLOORS-1:0]      RST_SENSOR  = FLOORS'(1) << START_FLOOR;

  logic [FLOOR_WIDTH-1:0] floor_q, floor_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [DPOS_W-1:0]      dpos_q, dpos_d;
  logic                   aligned, at_top, at_bottom, opening, move_ok, aligned_d;

  always_comb begin
    floor_d   = floor_q;
    tick_d    = tick_q;
    dpos_d    = dpos_q;
    aligned   = (tick_q == '0);
    at_top    = aligned && (floor_q == TOP_FLOOR);
    at_bottom = aligned && (floor_q == '0);
    opening   = (door == 2'd1) && aligned;

    if (opening) begin
      if (dpos_q != DPOS_OPEN) dpos_d = dpos_q + DPOS_W'(1);
    end else if (door == 2'd2) begin
      if (dpos_q != '0) dpos_d = dpos_q - DPOS_W'(1);
    end

    // Opening and motion are mutually exclusive; an opening request on a closed door wins.
    move_ok = (dpos_q == '0) && !opening;

    if (move_ok) begin
      case (engine)
        2'd2: if (!at_top) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            floor_d = floor_q + FLOOR_WIDTH'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        2'd1: if (!at_bottom) begin
          if (tick_q == '0) begin
            floor_d = floor_q - FLOOR_WIDTH'(1);
            tick_d  = TICK_LAST;
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
        default: ;
      endcase
    end

    aligned_d = (tick_d == '0);
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      floor_q      <= RST_FLOOR;
      tick_q       <= '0;
      dpos_q       <= '0;
      sensor_door  <= 2'd2;
      floor_sensor <= RST_SENSOR;
      floor_pos    <= RST_FLOOR;
      sensor_up    <= (RST_FLOOR == TOP_FLOOR);
      sensor_down  <= (RST_FLOOR == '0);
    end else begin
      floor_q      <= floor_d;
      tick_q       <= tick_d;
      dpos_q       <= dpos_d;
      sensor_door  <= (dpos_d == '0) ? 2'd2 : (dpos_d == DPOS_OPEN) ? 2'd1 : 2'd0;
      floor_sensor <= aligned_d ? (FLOORS'(1) << floor_d) : '0;
      floor_pos    <= floor_d;
      sensor_up    <= aligned_d && (floor_d == TOP_FLOOR);
      sensor_down  <= aligned_d && (floor_d == '0);
    end
  end

`ifdef PLANT_FAULT_EN
  logic illegal;

  always_comb begin
    illegal = (((engine == 2'd1) || (engine == 2'd2)) && (dpos_q != '0))
           || ((engine == 2'd2) && at_top)
           || ((engine == 2'd1) && at_bottom)
           || ((door == 2'd1) && !aligned)
           || (engine == 2'd3)
           || (door == 2'd3);
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) fault <= 1'b0;
    else if (illegal) fault <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_elevator_plant_model.sv
// Directed self-checking bench for elevator_plant_model (4 floors, engine 4, door 3).
// Fault-flag checks are included when PLANT_FAULT_EN is defined.
module tb_elevator_plant_model;

  logic       clock = 1'b0;
  logic       an_reset = 1'b0;
  logic [1:0] engine = 2'd0;
  logic [1:0] door = 2'd0;
  logic [1:0] sensor_door;
  logic [3:0] floor_sensor;
  logic [1:0] floor_pos;
  logic       sensor_up;
  logic       sensor_down;
`ifdef PLANT_FAULT_EN
  logic       fault;
`endif

  int checks = 0;
  int failures = 0;

  elevator_plant_model #(
    .FLOORS(4), .FLOOR_WIDTH(2), .DELAY_ENGINE(4), .DELAY_DOOR(3), .START_FLOOR(0)
  ) dut (
    .clock(clock),
    .an_reset(an_reset),
    .engine(engine),
    .door(door),
    .sensor_door(sensor_door),
    .floor_sensor(floor_sensor),
    .floor_pos(floor_pos),
    .sensor_up(sensor_up),
    .sensor_down(sensor_down)
`ifdef PLANT_FAULT_EN
    ,
    .fault(fault)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " floor_pos"}, floor_pos, 0);
    check({tag, " floor_sensor"}, floor_sensor, 4'b0001);
    check({tag, " sensor_down"}, sensor_down, 1);
    check({tag, " sensor_up"}, sensor_up, 0);
    check({tag, " sensor_door"}, sensor_door, 2);
`ifdef PLANT_FAULT_EN
    check({tag, " fault"}, fault, 0);
`endif
  endtask

  task automatic pulse_reset();
    #2 an_reset = 1'b0;
    #2 an_reset = 1'b1;
    step(1);
  endtask

  initial begin
    // 1: reset state
    #12;
    check_reset_outputs("reset");
    an_reset = 1'b1;
    step(1);
    check_reset_outputs("idle after reset");

    // 2: one floor up takes four edges, car between floors on edges 1-3
    engine = 2'd2;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check("up span floor_sensor", floor_sensor, 0);
      check("up span floor_pos", floor_pos, 0);
    end
    step(1);
    check("arrive f1 floor_pos", floor_pos, 1);
    check("arrive f1 floor_sensor", floor_sensor, 4'b0010);
    check("arrive f1 sensor_down", sensor_down, 0);
    engine = 2'd0;
    step(3);
    check("hold f1 floor_pos", floor_pos, 1);
    check("hold f1 floor_sensor", floor_sensor, 4'b0010);

    // 3: door open, interlocked engine, door close
    door = 2'd1;
    step(1); check("open e1 sensor_door", sensor_door, 0);
    step(1); check("open e2 sensor_door", sensor_door, 0);
    step(1); check("open e3 sensor_door", sensor_door, 1);
    door = 2'd0;
    engine = 2'd2;
    step(1);
    check("interlock floor_sensor", floor_sensor, 4'b0010);
    check("interlock floor_pos", floor_pos, 1);
    check("interlock sensor_door", sensor_door, 1);
`ifdef PLANT_FAULT_EN
    check("interlock fault", fault, 1);
`endif
    engine = 2'd0;
    door = 2'd2;
    step(1); check("close e1 sensor_door", sensor_door, 0);
    step(1); check("close e2 sensor_door", sensor_door, 0);
    step(1); check("close e3 sensor_door", sensor_door, 2);
    door = 2'd0;

    // back down to floor 0
    engine = 2'd1;
    step(1);
    check("down start floor_pos", floor_pos, 0);
    check("down start floor_sensor", floor_sensor, 0);
    step(3);
    check("arrive f0 floor_pos", floor_pos, 0);
    check("arrive f0 floor_sensor", floor_sensor, 4'b0001);
    check("arrive f0 sensor_down", sensor_down, 1);

    // 4: mid-span reversal returns to floor 0 with no penalty
    engine = 2'd2;
    step(2);
    check("rev mid floor_sensor", floor_sensor, 0);
    check("rev mid floor_pos", floor_pos, 0);
    engine = 2'd1;
    step(1);
    check("rev back1 floor_sensor", floor_sensor, 0);
    step(1);
    check("rev back2 floor_pos", floor_pos, 0);
    check("rev back2 floor_sensor", floor_sensor, 4'b0001);

    // simultaneous open and up on a closed door: door wins, car holds
    engine = 2'd2;
    door = 2'd1;
    step(1);
    check("door wins sensor_door", sensor_door, 0);
    check("door wins floor_sensor", floor_sensor, 4'b0001);
    engine = 2'd0;
    door = 2'd2;
    step(1);
    check("door wins reclose", sensor_door, 2);
    door = 2'd0;

    // 5: top stop, fault from a clean reset
    pulse_reset();
    check_reset_outputs("reset before top");
    engine = 2'd2;
    step(12);
    check("arrive f3 floor_pos", floor_pos, 3);
    check("arrive f3 floor_sensor", floor_sensor, 4'b1000);
    check("arrive f3 sensor_up", sensor_up, 1);
`ifdef PLANT_FAULT_EN
    check("arrive f3 fault", fault, 0);
`endif
    step(5);
    check("top stop floor_pos", floor_pos, 3);
    check("top stop sensor_up", sensor_up, 1);
    check("top stop floor_sensor", floor_sensor, 4'b1000);
`ifdef PLANT_FAULT_EN
    check("top stop fault", fault, 1);
`endif
    engine = 2'd0;

    // 6: asynchronous reset mid-span (floor 1, tick 2)
    pulse_reset();
    engine = 2'd2;
    step(6);
    engine = 2'd0;
    check("mid span floor_pos", floor_pos, 1);
    check("mid span floor_sensor", floor_sensor, 0);
    #2 an_reset = 1'b0;
    #1;
    check_reset_outputs("async reset");
    an_reset = 1'b1;
    step(1);
    check_reset_outputs("after async reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
